shift_left_deserializer: RTL and testbench
==========================================

# shift_left_deserializer

Serial-in/parallel-out receiver that rebuilds words from the MSB-first bit stream of the team's shift-left serializer. It samples `si` on strobed cycles, counts bits, presents the assembled word on `q` with a one-cycle `q_valid` pulse, and flags framing errors. It sits at the receive end of the serial link, feeding parallel consumers.

## Interface
- `WIDTH`, 8: word length in bits; at least 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `si`  in  1  serial data bit, MSB first.
- `sen`  in  1  bit strobe; `si` is sampled only when `sen`=1.
- `sstart`  in  1  frame start; qualified by `sen`, marks the current bit as the word MSB.
- `q`  out  WIDTH  last completed word; holds until the next completion.
- `q_valid`  out  1  one-cycle pulse: `q` updated this cycle.
- `busy`  out  1  frame in progress.
- `frame_err`  out  1  sticky framing error; cleared by reset or the next good completion.

## Operation
- States: IDLE, SHIFT, plus PARITY (only when the parity feature is compiled in).
- IDLE: `sen`&`sstart` loads `si` into shift register bit 0, sets count=1, and moves to SHIFT. `sen` without `sstart` is ignored.
- SHIFT: each `sen` shifts left, `sr <= {sr[WIDTH-2:0], si}`, and increments the count.
- When the strobe that brings the count to WIDTH arrives: `q <= sr` with the new bit appended, `q_valid`=1 on the next cycle, then return to IDLE (or go to PARITY).
- `sen`=0 cycles in SHIFT freeze all state. There is no timeout.
- `sstart`&`sen` in SHIFT (early restart): set `frame_err`, drop the partial word without updating `q`, and restart the frame with this bit as the MSB (count=1).
- `sstart`&`sen` on the same cycle as the final bit: treated as the final bit and completes normally. `sstart` is ignored on the last bit.
- A good completion clears `frame_err`.
- The bit counter is $clog2(WIDTH+1) bits wide, compared with WIDTH, and never wraps.

## Timing
- Reset values: `q`=0, `q_valid`=0, `busy`=0, `frame_err`=0, state IDLE, count 0, shift register 0.
- Latency: `q`/`q_valid` are registered and assert on the clock edge that samples the last data bit. They are visible in the cycle after that strobe.
- `busy` is 1 from the edge after the start bit is sampled until the edge that completes the frame.
- Back-to-back frames are allowed: `sstart` on the strobe directly after the last bit begins a new frame with no gap.
- Reset asserted mid-frame: immediate return to IDLE. The partial word is discarded. No `q_valid` is produced.

## Configuration
- `SHIFT_DESER_PARITY_EN` defined:
  - After WIDTH data bits, one extra strobed bit is expected: even parity over the data.
  - The extra bit is received in state PARITY.
  - `q`/`q_valid` update only when parity matches.
  - On a mismatch, set `frame_err`, leave `q` unchanged, and produce no pulse.
  - `sstart` during PARITY is treated as an early restart.
- `SHIFT_DESER_PARITY_EN` undefined: no PARITY state, no parity logic, and completion follows the last data bit directly.

## Structure
- Shared package `shift_deser_pkg`:
  - state enum `deser_state_t` (IDLE, SHIFT, PARITY).
  - default `WIDTH` constant.
  - localparam function for the counter width.
- One sub-module, `deser_bit_counter`:
  - ports: clear, load-one, increment-on-`sen`, `done` compare output.
- The top level holds the FSM, shift register and output registers.

## Test plan
- Reset, then frame 1,0,1,0,1,1,1,1 with `sen`=1 every cycle and `sstart` on the first bit -> `q`=8'hAF, one `q_valid` pulse, `busy` low afterwards, `frame_err`=0.
- Same frame with `sen` low on every other cycle -> identical `q`=8'hAF. `q_valid` comes only after the 8th strobe.
- `sstart` on bit 5 of a frame, then 8 full bits of 8'h3C -> `frame_err`=1 after the restart, then `q`=8'h3C, `q_valid` pulse, `frame_err` cleared.
- Frames 8'hAF and 8'h50 back-to-back with no idle cycle -> two `q_valid` pulses 8 cycles apart carrying AF then 50.
- `rst_n` pulsed low after 4 bits -> outputs at reset values, no `q_valid`. A following frame of 8'hFF gives `q`=8'hFF.
- With `SHIFT_DESER_PARITY_EN`: 8'hAF followed by parity bit 0 -> `q`=8'hAF. With parity bit 1 instead -> `frame_err`=1, `q` unchanged, no pulse.

Source files
------------

// File: rtl/shift_deser_pkg.sv
// Shared definitions for the shift-left deserializer: FSM state type,
// default word length and the bit-counter width helper.
package shift_deser_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } deser_state_t;

  // Counter must hold 0..width inclusive, so it never wraps at a full word.
  function automatic int deser_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// Bit counter for the shift-left deserializer. Counts strobed bits of the
// current frame and flags the strobe that brings the count to WIDTH.
module deser_bit_counter
  import shift_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load_one,
  input  logic inc,
  output logic done
);

  localparam int CW = deser_cnt_width(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_reg;

  // Load-one wins over clear, clear over increment; saturate at WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load_one) begin
      count_reg <= CW'(1);
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != FULL)) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // High on the strobe whose increment makes the count equal WIDTH.
  assign done = inc && (count_reg == LAST);

endmodule

// File: rtl/shift_left_deserializer.sv
// Serial-in/parallel-out receiver for the MSB-first shift-left serializer.
// Optional feature macro: SHIFT_DESER_PARITY_EN adds a trailing even-parity
// bit per frame, received in state PARITY.
module shift_left_deserializer
  import shift_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             si,
  input  logic             sen,
  input  logic             sstart,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
  output logic             frame_err
);

  // Without parity the final data bit goes straight from si into q, so the
  // shift register only ever needs to hold the first WIDTH-1 bits. With
  // parity the full word must be held while the parity bit is awaited.
`ifdef SHIFT_DESER_PARITY_EN
  localparam int SR_W = WIDTH;
`else
  localparam int SR_W = WIDTH - 1;
`endif

  deser_state_t     state_reg;
  logic [SR_W-1:0]  sr_reg;
  logic [WIDTH-1:0] sr_shift;
  logic [SR_W-1:0]  sr_load;
  logic             cnt_clear;
  logic             cnt_load;
  logic             cnt_inc;
  logic             cnt_done;

  // Shift-left view of the register with the current serial bit appended.
  assign sr_shift[0] = si;
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
    assign sr_shift[gi] = sr_reg[gi-1];
  end

  // Start-of-frame value: the MSB sits in bit 0, everything else cleared.
  always_comb begin
    sr_load    = '0;
    sr_load[0] = si;
  end

  deser_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .load_one (cnt_load),
    .inc      (cnt_inc),
    .done     (cnt_done)
  );

  // Counter control: a start bit reloads to one unless it is the final data
  // bit, where sstart is ignored and the frame completes.
  always_comb begin
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_load = sen && sstart;
      end
      SHIFT: begin
        cnt_inc  = sen;
        cnt_load = sen && sstart && !cnt_done;
`ifndef SHIFT_DESER_PARITY_EN
        cnt_clear = cnt_done;
`endif
      end
`ifdef SHIFT_DESER_PARITY_EN
      PARITY: begin
        cnt_load  = sen && sstart;
        cnt_clear = sen;
      end
`endif
      default: begin
        cnt_clear = 1'b1;
      end
    endcase
  end

  // Frame FSM with shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      q         <= '0;
      q_valid   <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sen && sstart) begin
            sr_reg    <= sr_load;
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (sen) begin
            if (cnt_done) begin
`ifdef SHIFT_DESER_PARITY_EN
              sr_reg    <= sr_shift;
              state_reg <= PARITY;
`else
              q         <= sr_shift;
              q_valid   <= 1'b1;
              frame_err <= 1'b0;
              busy      <= 1'b0;
              state_reg <= IDLE;
`endif
            end else if (sstart) begin
              // Early restart: drop the partial word, this bit is the new MSB.
              frame_err <= 1'b1;
              sr_reg    <= sr_load;
            end else begin
              sr_reg <= sr_shift[SR_W-1:0];
            end
          end
        end
`ifdef SHIFT_DESER_PARITY_EN
        PARITY: begin
          if (sen) begin
            if (sstart) begin
              frame_err <= 1'b1;
              sr_reg    <= sr_load;
              state_reg <= SHIFT;
            end else if (si == (^sr_reg)) begin
              q         <= sr_reg;
              q_valid   <= 1'b1;
              frame_err <= 1'b0;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end else begin
              frame_err <= 1'b1;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
`endif
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_left_deserializer.sv
// Self-checking bench for shift_left_deserializer: directed frames from the
// test plan followed by randomized strobes, all checked every cycle against
// a queue-based model of the frame rules.
module tb_shift_left_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         si;
  logic         sen;
  logic         sstart;
  logic [W-1:0] q;
  logic         q_valid;
  logic         busy;
  logic         frame_err;

  shift_left_deserializer #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .si        (si),
    .sen       (sen),
    .sstart    (sstart),
    .q         (q),
    .q_valid   (q_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: received bits kept in a queue, word packed on demand.
  bit           m_bits[$];
  logic [W-1:0] m_q;
  bit           m_qv;
  bit           m_busy;
  bit           m_err;
  bit           m_par;   // waiting for the parity bit

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] w = '0;
    foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
    return w;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_q = '0; m_qv = 0; m_busy = 0; m_err = 0; m_par = 0;
  endtask

  task automatic model_edge(input bit s_en, input bit s_st, input bit s_i);
    logic [W-1:0] w;
    m_qv = 0;
    if (!s_en) return;
    if (!m_busy) begin
      if (s_st) begin
        m_bits.delete(); m_bits.push_back(s_i); m_busy = 1;
      end
    end else if (m_par) begin
      m_par = 0;
      if (s_st) begin
        m_err = 1; m_bits.delete(); m_bits.push_back(s_i);
      end else begin
        w = pack_bits();
        m_busy = 0;
        if (s_i == bit'($countones(w) % 2)) begin
          m_q = w; m_qv = 1; m_err = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (m_bits.size() == W - 1) begin
      m_bits.push_back(s_i);
`ifdef SHIFT_DESER_PARITY_EN
      m_par = 1;
`else
      m_q = pack_bits(); m_qv = 1; m_err = 0; m_busy = 0;
`endif
    end else if (s_st) begin
      m_err = 1; m_bits.delete(); m_bits.push_back(s_i);
    end else begin
      m_bits.push_back(s_i);
    end
  endtask

  // One clock: drive on the falling edge, update model on the rising edge,
  // compare just after it.
  task automatic step(input bit s_en, input bit s_st, input bit s_i);
    @(negedge clk);
    sen = s_en; sstart = s_st; si = s_i;
    @(posedge clk);
    model_edge(s_en, s_st, s_i);
    #1;
    check("q_valid", q_valid, m_qv);
    check("q", q, m_q);
    check("busy", busy, m_busy);
    check("frame_err", frame_err, m_err);
    $display("cyc sen=%0b sst=%0b si=%0b -> q=%02h qv=%0b busy=%0b err=%0b",
             s_en, s_st, s_i, q, q_valid, busy, frame_err);
  endtask

  // Send one word MSB first; gap inserts an unstrobed cycle between bits.
  // flip inverts the parity bit (parity build only).
  task automatic send_word(input logic [W-1:0] w, input bit gap, input bit flip,
                           input bit err_after_first);
    for (int i = 0; i < W; i++) begin
      if (gap && i > 0) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step(1'b1, i == 0, w[W-1-i]);
      if (i == 0 && err_after_first) check("restart_err", frame_err, 1);
      if (i < W - 1) check("mid_no_valid", q_valid, 0);
    end
`ifdef SHIFT_DESER_PARITY_EN
    step(1'b1, 1'b0, 1'(($countones(w) % 2) != 0) ^ flip);
`endif
    if (!flip) begin
      check("word_valid", q_valid, 1);
      check("word_q", q, w);
      check("word_busy", busy, 0);
      check("word_err", frame_err, 0);
    end else begin
      check("bad_par_valid", q_valid, 0);
      check("bad_par_err", frame_err, 1);
    end
  endtask

  initial begin
    logic [W-1:0] q_before;
    rst_n = 1'b0; sen = 1'b0; sstart = 1'b0; si = 1'b0;
    model_reset();
    #12;
    check("rst_q", q, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle strobes without sstart are ignored.
    step(1'b1, 1'b0, 1'b1);
    check("idle_busy", busy, 0);

    // Continuous strobes, then strobes on every other cycle.
    send_word(8'hAF, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("after_pulse", q_valid, 0);
    send_word(8'hAF, 1'b1, 1'b0, 1'b0);

    // Early restart on bit 5, then a full 3C frame.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    send_word(8'h3C, 1'b0, 1'b0, 1'b1);

    // Back-to-back frames, no idle cycle.
    send_word(8'hAF, 1'b0, 1'b0, 1'b0);
    send_word(8'h50, 1'b0, 1'b0, 1'b0);

    // sstart on the final bit completes normally.
    for (int i = 0; i < W; i++) step(1'b1, (i == 0) || (i == W - 1), 1'(i % 2));
`ifndef SHIFT_DESER_PARITY_EN
    check("last_sstart_q", q, 8'h55);
    check("last_sstart_valid", q_valid, 1);
`else
    step(1'b1, 1'b0, 1'b0);
    check("last_sstart_q", q, 8'h55);
`endif

    // Reset asserted mid-frame.
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_q", q, 0);
    check("midrst_q_valid", q_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_err", frame_err, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    check("midrst_no_valid", q_valid, 0);
    send_word(8'hFF, 1'b0, 1'b0, 1'b0);

`ifdef SHIFT_DESER_PARITY_EN
    send_word(8'hAF, 1'b0, 1'b0, 1'b0);
    q_before = q;
    send_word(8'h3C, 1'b0, 1'b1, 1'b0);
    check("bad_par_q_held", q, q_before);
`else
    q_before = q;
    check("final_q_held", q_before, 8'hFF);
`endif

    // Randomized strobes, starts and data.
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
